ysyx_24110006_wbu: RTL and testbench
====================================

# ysyx_24110006_wbu

Writeback stage of the NPC core: accepts completed results from the upstream EXU/LSU over a valid/ready handshake, formats load data, and drives the register file write port one cycle later. It also owns the register scoreboard that decode uses to stall on RAW and WAW hazards. It sits between the LSU output and the register file write port.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, datapath width
- i_clock  in  1  core clock
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream result valid
- o_ready  out  1  stage can accept
- i_rd  in  ADDR_WIDTH  destination register
- i_rd_wen  in  1  instruction writes rd
- i_result  in  DATA_WIDTH  ALU/CSR result
- i_is_load  in  1  select formatted load data instead of i_result
- i_load_size  in  2  0 byte, 1 half, 2 word (3 reserved)
- i_load_unsigned  in  1  zero-extend instead of sign-extend
- i_addr_low  in  2  load address bits [1:0]
- i_rdata  in  DATA_WIDTH  raw aligned memory word
- i_hold  in  1  freeze writeback (debug halt / ebreak)
- o_wen  out  1  register file write enable
- o_waddr  out  ADDR_WIDTH  register file write address
- o_wdata  out  DATA_WIDTH  register file write data
- o_retire  out  1  one-cycle pulse per retired instruction
- i_issue  in  1  decode issues an instruction with rd write
- i_issue_rd  in  ADDR_WIDTH  its destination
- i_chk_rs1, i_chk_rs2  in  ADDR_WIDTH  decode source indices
- o_rs1_busy, o_rs2_busy  out  1  source has a pending write

## Operation
- One-entry output slot (valid, rd, wen, data). Handshake fires when i_valid && o_ready; o_ready = !slot_valid || !i_hold.
- On fire: slot loads rd, wen = i_rd_wen && (i_rd != 0), data = i_is_load ? formatted load : i_result.
- Load formatting: byte = i_rdata[8*i_addr_low +: 8]; half = i_rdata[16*i_addr_low[1] +: 16]; word ignores i_addr_low; extend to DATA_WIDTH per i_load_unsigned. Half with i_addr_low[0]=1 or size 3: simulation assertion, data undefined.
- Drain: slot_valid && !i_hold -> o_wen = slot wen, o_retire = 1, slot empties unless refilled the same edge.
- Scoreboard: busy bit per register. i_issue with i_issue_rd != 0 sets busy; drain with wen clears busy[o_waddr]. Same-register set and clear in one cycle: set wins. x0 never busy.
- Busy outputs are combinational from registered state; a clear in the current cycle is not forwarded (regfile not yet written).
- Issuing to an already-busy rd is a protocol violation (decode must stall on WAW); asserted in simulation.

## Timing
- Reset: slot empty, o_wen 0, o_waddr 0, o_wdata 0, o_retire 0, all busy 0, o_ready 1, counter 0.
- Latency: accept at edge N -> o_wen high cycle N+1 -> regfile and busy updated at end of N+1.
- Throughput: one result per cycle with i_hold low.
- i_hold high: o_wen/o_retire low, slot retained, o_ready low while full; writes resume the cycle after i_hold falls.
- Reset mid-operation discards the slot with no write; busy bits clear.

## Configuration
- YSYX_24110006_WBU_PERF_EN defined: adds output o_retire_cnt (64 bits), incremented on every o_retire, wraps at 2^64, reset 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package ysyx_24110006_pkg: load size encodings (LS_BYTE, LS_HALF, LS_WORD), ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module ysyx_24110006_load_align: combinational load extraction and extension.

## Test plan
- Reset then ALU result rd=5, 0x1234_5678 -> next cycle o_wen=1, o_waddr=5, o_wdata=0x1234_5678, o_retire=1.
- Load byte, i_rdata=0x80FF_7F01, addr_low=3, signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080; half addr_low=2 signed -> 0xFFFF_80FF.
- rd=0 with i_rd_wen=1 -> o_wen=0, o_retire=1, no busy change.
- Issue rd=7, check rs1=7 -> busy=1; writeback rd=7 -> busy still 1 that cycle, 0 next; issue rd=7 same cycle as clear -> remains 1.
- Back-to-back results with i_hold for 3 cycles mid-stream -> o_ready low while full, no lost or duplicated writes, order preserved.
- PERF_EN: 10 retirements -> o_retire_cnt=10; assert i_reset mid-stream -> counter, slot and busy all 0.

Source files
------------

// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the ysyx_24110006 core: datapath width defaults and
// the load size encoding used between the LSU and the writeback stage.
package ysyx_24110006_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } load_size_e;

endpackage

// File: rtl/ysyx_24110006_load_align.sv
// Combinational load data extraction: picks the byte/half/word lane out of the
// raw aligned memory word and sign- or zero-extends it to the datapath width.
module ysyx_24110006_load_align
    import ysyx_24110006_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [1:0]            size_i,
    input  logic                  zext_i,
    input  logic [1:0]            addr_low_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign byte_w = rdata_i[{addr_low_i, 3'b000} +: 8];
    assign half_w = rdata_i[{addr_low_i[1], 4'b0000} +: 16];

    // Reserved size falls through to the raw word; the result is undefined anyway.
    always_comb begin
        data_o = rdata_i;
        case (load_size_e'(size_i))
            LS_BYTE: data_o = {{(DATA_WIDTH-8){byte_w[7] & ~zext_i}}, byte_w};
            LS_HALF: data_o = {{(DATA_WIDTH-16){half_w[15] & ~zext_i}}, half_w};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_wbu.sv
// Writeback stage: one-entry result slot feeding the register file write port,
// plus the per-register busy scoreboard used by decode for RAW/WAW stalls.
// Optional retirement counter enabled by YSYX_24110006_WBU_PERF_EN.
module ysyx_24110006_wbu
    import ysyx_24110006_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic                  i_rd_wen,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_is_load,
    input  logic [1:0]            i_load_size,
    input  logic                  i_load_unsigned,
    input  logic [1:0]            i_addr_low,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_hold,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_retire,
    input  logic                  i_issue,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    input  logic [ADDR_WIDTH-1:0] i_chk_rs1,
    input  logic [ADDR_WIDTH-1:0] i_chk_rs2,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
`ifdef YSYX_24110006_WBU_PERF_EN
    ,
    output logic [63:0]           o_retire_cnt
`endif
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  slot_valid_q, slot_valid_d;
    logic                  slot_wen_q, slot_wen_d;
    logic [ADDR_WIDTH-1:0] slot_rd_q, slot_rd_d;
    logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  fire, drain, issue_set, clr;

    ysyx_24110006_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .size_i    (i_load_size),
        .zext_i    (i_load_unsigned),
        .addr_low_i(i_addr_low),
        .rdata_i   (i_rdata),
        .data_o    (load_data)
    );

    assign o_ready   = !slot_valid_q || !i_hold;
    assign fire      = i_valid && o_ready;
    assign drain     = slot_valid_q && !i_hold;
    assign clr       = drain && slot_wen_q;
    assign issue_set = i_issue && (i_issue_rd != '0);

    assign o_wen    = clr;
    assign o_retire = drain;
    assign o_waddr  = slot_rd_q;
    assign o_wdata  = slot_data_q;

    // A refill on the draining edge keeps the slot occupied.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_wen_d   = slot_wen_q;
        slot_rd_d    = slot_rd_q;
        slot_data_d  = slot_data_q;
        if (drain) slot_valid_d = 1'b0;
        if (fire) begin
            slot_valid_d = 1'b1;
            slot_wen_d   = i_rd_wen && (i_rd != '0);
            slot_rd_d    = i_rd;
            slot_data_d  = i_is_load ? load_data : i_result;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            slot_valid_q <= 1'b0;
            slot_wen_q   <= 1'b0;
            slot_rd_q    <= '0;
            slot_data_q  <= '0;
            busy_q       <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_wen_q   <= slot_wen_d;
            slot_rd_q    <= slot_rd_d;
            slot_data_q  <= slot_data_d;
            busy_q       <= busy_d;
        end
    end

    // Set beats clear on the same register; x0 is hardwired idle.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_reg
            assign busy_d[gi] = (issue_set && (i_issue_rd == ADDR_WIDTH'(gi)))
                             || (busy_q[gi] && !(clr && (slot_rd_q == ADDR_WIDTH'(gi))));
        end
    end

    assign o_rs1_busy = busy_q[i_chk_rs1];
    assign o_rs2_busy = busy_q[i_chk_rs2];

`ifdef YSYX_24110006_WBU_PERF_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) retire_cnt_q <= '0;
        else if (drain) retire_cnt_q <= retire_cnt_q + 64'd1;
    end

    assign o_retire_cnt = retire_cnt_q;
`endif

`ifndef SYNTHESIS
    a_load_fmt: assert property (@(posedge i_clock) disable iff (i_reset)
        (fire && i_is_load) |-> !((i_load_size == LS_RSVD)
                                  || (i_load_size == LS_HALF && i_addr_low[0])));

    // Re-issue is legal only against the write that is retiring this cycle.
    a_waw: assert property (@(posedge i_clock) disable iff (i_reset)
        issue_set |-> (!busy_q[i_issue_rd] || (clr && slot_rd_q == i_issue_rd)));
`endif

endmodule

// File: tb/tb_ysyx_24110006_wbu.sv
// Scoreboard bench for ysyx_24110006_wbu; define YSYX_24110006_WBU_PERF_EN to
// also exercise the retirement counter.
module tb_ysyx_24110006_wbu;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, o_ready, i_rd_wen, i_is_load, i_load_unsigned, i_hold;
    logic [4:0]  i_rd, o_waddr, i_issue_rd, i_chk_rs1, i_chk_rs2;
    logic [31:0] i_result, i_rdata, o_wdata;
    logic [1:0]  i_load_size, i_addr_low;
    logic        o_wen, o_retire, i_issue, o_rs1_busy, o_rs2_busy;
`ifdef YSYX_24110006_WBU_PERF_EN
    logic [63:0] o_retire_cnt;
`endif

    ysyx_24110006_wbu dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_result(i_result), .i_is_load(i_is_load),
        .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
        .i_addr_low(i_addr_low), .i_rdata(i_rdata), .i_hold(i_hold),
        .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_retire(o_retire),
        .i_issue(i_issue), .i_issue_rd(i_issue_rd), .i_chk_rs1(i_chk_rs1),
        .i_chk_rs2(i_chk_rs2), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy)
`ifdef YSYX_24110006_WBU_PERF_EN
        , .o_retire_cnt(o_retire_cnt)
`endif
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   sent_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] result,
                        input logic is_load, input logic [1:0] size, input logic zext,
                        input logic [1:0] low, input logic [31:0] rdata,
                        input logic [31:0] exp_data);
        exp_t e;
        int   n;
        i_valid = 1'b1; i_rd = rd; i_rd_wen = wen; i_result = result;
        i_is_load = is_load; i_load_size = size; i_load_unsigned = zext;
        i_addr_low = low; i_rdata = rdata;
        #1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge i_clock);
            #2;
            n++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout rd=%0d actual_ready=0 required_ready=1", rd);
            i_valid = 1'b0;
        end else begin
            e.wen = wen && (rd != 5'd0);
            e.addr = rd;
            e.data = exp_data;
            exp_q.push_back(e);
            sent_cnt++;
            @(posedge i_clock);
            #1;
            i_valid = 1'b0;
        end
    endtask

    // Monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge i_clock) begin
        exp_t e;
        if (!i_reset) begin
            if (o_retire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire waddr=%0d wdata=0x%0h required=none",
                             o_waddr, o_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("writeback_rd%0d", e.addr), {26'd0, o_wen, o_waddr, o_wdata},
                        {26'd0, e});
                    $display("retire wen=%0d waddr=%0d wdata=0x%08h", o_wen, o_waddr, o_wdata);
                end
            end else if (o_wen) begin
                checks++;
                failures++;
                $display("FAIL wen_without_retire actual_wen=1 required_wen=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_rd = '0; i_rd_wen = 1'b0; i_result = '0;
        i_is_load = 1'b0; i_load_size = '0; i_load_unsigned = 1'b0; i_addr_low = '0;
        i_rdata = '0; i_hold = 1'b0; i_issue = 1'b0; i_issue_rd = '0;
        i_chk_rs1 = 5'd7; i_chk_rs2 = 5'd8;
        #2;
        chk("reset_ready", 64'(o_ready), 64'd1);
        chk("reset_wen", 64'(o_wen), 64'd0);
        chk("reset_waddr", 64'(o_waddr), 64'd0);
        chk("reset_wdata", 64'(o_wdata), 64'd0);
        chk("reset_retire", 64'(o_retire), 64'd0);
        chk("reset_busy", {62'd0, o_rs1_busy, o_rs2_busy}, 64'd0);
`ifdef YSYX_24110006_WBU_PERF_EN
        chk("reset_cnt", o_retire_cnt, 64'd0);
`endif
        cyc(2);
        i_reset = 1'b0;
        cyc(1);

        send(5'd5, 1'b1, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h1234_5678);
        // Loads from 0x80FF_7F01
        send(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        send(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b1, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
        send(5'd4, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd1, 1'b0, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
        send(5'd4, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd1, 1'b1, 2'd2, 32'h80FF_7F01, 32'h0000_80FF);
        send(5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 2'd0, 32'h80FF_7F01, 32'h0000_0001);
        send(5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
        send(5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        send(5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd1, 1'b0, 2'd0, 32'h80FF_7F01, 32'h0000_7F01);
        send(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 2'd3, 32'h80FF_7F01, 32'h80FF_7F01);
        // x0 destination and wen=0 retire without writing
        send(5'd0, 1'b1, 32'hAAAA_5555, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'hAAAA_5555);
        send(5'd4, 1'b0, 32'h5555_AAAA, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h5555_AAAA);
        cyc(2);
        chk("x0_no_busy", {62'd0, o_rs1_busy, o_rs2_busy}, 64'd0);

        // Scoreboard set / clear / set-wins
        i_issue = 1'b1; i_issue_rd = 5'd7;
        cyc(1);
        i_issue = 1'b0;
        chk("busy_set_rs1", 64'(o_rs1_busy), 64'd1);
        chk("busy_other_rs2", 64'(o_rs2_busy), 64'd0);
        send(5'd7, 1'b1, 32'h0000_0077, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_0077);
        chk("busy_no_forward", 64'(o_rs1_busy), 64'd1);
        cyc(1);
        chk("busy_cleared", 64'(o_rs1_busy), 64'd0);
        i_issue = 1'b1; i_issue_rd = 5'd7;
        cyc(1);
        i_issue = 1'b0;
        chk("busy_reset_again", 64'(o_rs1_busy), 64'd1);
        send(5'd7, 1'b1, 32'h0000_0700, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_0700);
        i_issue = 1'b1; i_issue_rd = 5'd7;
        cyc(1);
        i_issue = 1'b0;
        chk("busy_set_wins", 64'(o_rs1_busy), 64'd1);
        send(5'd7, 1'b1, 32'h0000_0701, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_0701);
        cyc(1);
        chk("busy_final_clear", 64'(o_rs1_busy), 64'd0);

        // Back-to-back stream with a 3-cycle hold in the middle
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(5'(10 + k), 1'b1, 32'h1000 + 32'(k), 1'b0, 2'd0, 1'b0, 2'd0,
                         32'h0, 32'h1000 + 32'(k));
            end
            begin
                @(posedge i_clock);
                @(posedge i_clock);
                #1;
                i_hold = 1'b1;
                for (int h = 0; h < 3; h++) begin
                    #1;
                    chk($sformatf("hold_ready_c%0d", h), 64'(o_ready), 64'd0);
                    @(posedge i_clock);
                    #1;
                end
                i_hold = 1'b0;
            end
        join
        cyc(3);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation with a held slot and a busy register
        i_issue = 1'b1; i_issue_rd = 5'd9;
        cyc(1);
        i_issue = 1'b0;
        i_chk_rs1 = 5'd9;
        send(5'd9, 1'b1, 32'h0000_0999, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_0999);
        i_hold = 1'b1;
        cyc(1);
        chk("held_busy", 64'(o_rs1_busy), 64'd1);
        i_reset = 1'b1;
        exp_q.delete();
        sent_cnt = 0;
        i_hold = 1'b0;
        #1;
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_wen", 64'(o_wen), 64'd0);
        chk("midrst_retire", 64'(o_retire), 64'd0);
        chk("midrst_wdata", 64'(o_wdata), 64'd0);
        chk("midrst_busy", 64'(o_rs1_busy), 64'd0);
`ifdef YSYX_24110006_WBU_PERF_EN
        chk("midrst_cnt", o_retire_cnt, 64'd0);
`endif
        cyc(1);
        i_reset = 1'b0;
        cyc(3);

        for (int k = 0; k < 10; k++)
            send(5'(1 + k), 1'b1, 32'hC0DE_0000 + 32'(k), 1'b0, 2'd0, 1'b0, 2'd0,
                 32'h0, 32'hC0DE_0000 + 32'(k));
        cyc(3);
        chk("final_drained", 64'(exp_q.size()), 64'd0);
`ifdef YSYX_24110006_WBU_PERF_EN
        chk("retire_cnt", o_retire_cnt, 64'(sent_cnt));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
